ov5640_init_seq: RTL and testbench

Sequencer that walks the OV5640 register-init ROM and turns each 24-bit entry into an SCCB register write: {reg_addr[15:0], reg_data[7:0]}.
- Sits between the init table and the SCCB master in the camera_init path.
- Enforces the sensor power-up wait and the post-software-reset wait.
- Retries NACKed writes and reports done/error to the capture/SDRAM pipeline.

---
 rtl/ov5640_pkg.sv | 23 ++
 rtl/ov5640_delay_cnt.sv | 18 +
 rtl/ov5640_init_seq.sv | 131 +++++++++++++
 tb/tb_ov5640_init_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// ov5640_pkg: shared state encodings, SCCB soft-reset constants and ROM entry field positions for the OV5640 init sequencer.
package ov5640_pkg;
  typedef logic [3:0] state_t;
  localparam state_t ST_PWRUP      = 4'd0;
  localparam state_t ST_FETCH      = 4'd1;
  localparam state_t ST_WAIT_ROM   = 4'd2;
  localparam state_t ST_ISSUE      = 4'd3;
  localparam state_t ST_WAIT_DONE  = 4'd4;
  localparam state_t ST_SWRST_WAIT = 4'd5;
  localparam state_t ST_NEXT       = 4'd6;
  localparam state_t ST_DONE       = 4'd7;
  localparam state_t ST_ERROR      = 4'd8;
  localparam state_t ST_RD_ISSUE   = 4'd9;
  localparam state_t ST_RD_WAIT    = 4'd10;
  localparam logic [15:0] SCCB_SWRST_REG = 16'h3008;
  localparam int SWRST_BIT    = 7;
  localparam int REG_ADDR_MSB = 23;
  localparam int REG_ADDR_LSB = 8;
  localparam int REG_DATA_MSB = 7;
  function automatic logic is_swrst(input logic [15:0] a, input logic [7:0] d);
    return a == SCCB_SWRST_REG && d[SWRST_BIT];
  endfunction
endpackage

// File: rtl/ov5640_delay_cnt.sv
// ov5640_delay_cnt: loadable 32-bit down-counter; done is high during the last counted cycle (or when idle at zero).
// Ports: clk, reset (sync, active-high, reloads RESET_VAL), load/load_val (restart count), done.
module ov5640_delay_cnt #(
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        done
);
  logic [31:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= RESET_VAL;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 32'd1;
  assign done = cnt <= 32'd1;
endmodule

// File: rtl/ov5640_init_seq.sv
// ov5640_init_seq: walks the OV5640 register-init ROM and issues one SCCB write per entry, with power-up and soft-reset waits and NACK retries.
// Ports: clk, reset (sync, active-high), re_init (restart from DONE/ERROR), rom_addr/rom_q (registered ROM, 1-cycle latency),
//        wr_req/wr_addr/wr_data/wr_done/wr_ack_err (SCCB master handshake), busy, init_done, init_err, err_index.
// Optional: OV5640_INIT_READBACK_EN adds rd_req/rd_done/rd_data read-back verification with init_mismatch/mismatch_cnt.
module ov5640_init_seq import ov5640_pkg::*; #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned REG_NUM        = 250,
  parameter int unsigned POWERUP_CYCLES = 1000000,
  parameter int unsigned SWRESET_CYCLES = 250000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  re_init,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_q,
  output logic                  wr_req,
  output logic [15:0]           wr_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_done,
  input  logic                  wr_ack_err,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [ADDR_WIDTH-1:0] err_index
`ifdef OV5640_INIT_READBACK_EN
  ,
  output logic                  rd_req,
  input  logic                  rd_done,
  input  logic [7:0]            rd_data,
  output logic                  init_mismatch,
  output logic [7:0]            mismatch_cnt
`endif
);
  localparam int RW = $clog2(MAX_RETRY + 1);
`ifdef OV5640_INIT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [RW-1:0] retry_cnt;
  logic dly_done, dly_load, last, retry_out;
  logic [31:0] dly_val;
  assign rom_addr  = idx;
  assign wr_req    = state == ST_ISSUE;
  assign busy      = !(state == ST_DONE || state == ST_ERROR);
  assign last      = idx == ADDR_WIDTH'(REG_NUM - 1);
  assign retry_out = retry_cnt == RW'(MAX_RETRY);
  // Reload the shared counter on every entry into a delay state; reset itself preloads the power-up count.
  assign dly_load  = (nxt == ST_SWRST_WAIT && state != ST_SWRST_WAIT) || (nxt == ST_PWRUP && state != ST_PWRUP);
  assign dly_val   = nxt == ST_SWRST_WAIT ? 32'(SWRESET_CYCLES) : 32'(POWERUP_CYCLES);
  ov5640_delay_cnt #(.RESET_VAL(32'(POWERUP_CYCLES))) u_dly (
    .clk      (clk),
    .reset    (reset),
    .load     (dly_load),
    .load_val (dly_val),
    .done     (dly_done)
  );
  always_comb begin
    nxt = state;
    case (state)
      ST_PWRUP:      nxt = dly_done ? ST_FETCH : ST_PWRUP;
      ST_FETCH:      nxt = ST_WAIT_ROM;
      ST_WAIT_ROM:   nxt = ST_ISSUE;
      ST_ISSUE:      nxt = ST_WAIT_DONE;
      ST_WAIT_DONE:  nxt = !wr_done ? ST_WAIT_DONE :
                           wr_ack_err ? (retry_out ? ST_ERROR : ST_ISSUE) :
                           is_swrst(wr_addr, wr_data) ? ST_SWRST_WAIT :
                           (RB && wr_addr != SCCB_SWRST_REG) ? ST_RD_ISSUE : ST_NEXT;
      ST_SWRST_WAIT: nxt = dly_done ? ST_NEXT : ST_SWRST_WAIT;
      ST_NEXT:       nxt = last ? ST_DONE : ST_FETCH;
      ST_DONE,
      ST_ERROR:      nxt = re_init ? ST_PWRUP : state;
`ifdef OV5640_INIT_READBACK_EN
      ST_RD_ISSUE:   nxt = ST_RD_WAIT;
      ST_RD_WAIT:    nxt = rd_done ? ST_NEXT : ST_RD_WAIT;
`endif
      default:       nxt = ST_PWRUP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_PWRUP;
      idx       <= '0;
      retry_cnt <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      err_index <= '0;
    end else begin
      state <= nxt;
      if (state == ST_WAIT_ROM) begin
        wr_addr <= rom_q[REG_ADDR_MSB:REG_ADDR_LSB];
        wr_data <= rom_q[REG_DATA_MSB:0];
      end
      if (state == ST_WAIT_DONE && wr_done) begin
        if (!wr_ack_err) retry_cnt <= '0;
        else if (!retry_out) retry_cnt <= retry_cnt + RW'(1);
        else begin
          init_err  <= 1'b1;
          err_index <= idx;
        end
      end
      if (state == ST_NEXT) begin
        if (last) init_done <= 1'b1;
        else idx <= idx + ADDR_WIDTH'(1);
      end
      if ((state == ST_DONE || state == ST_ERROR) && re_init) begin
        idx       <= '0;
        retry_cnt <= '0;
        init_done <= 1'b0;
        init_err  <= 1'b0;
        err_index <= '0;
      end
    end
  end
`ifdef OV5640_INIT_READBACK_EN
  assign rd_req = state == ST_RD_ISSUE;
  always_ff @(posedge clk)
    if (reset) begin
      init_mismatch <= 1'b0;
      mismatch_cnt  <= '0;
    end else if (state == ST_RD_WAIT && rd_done && rd_data != wr_data) begin
      init_mismatch <= 1'b1;
      mismatch_cnt  <= mismatch_cnt + {7'd0, mismatch_cnt != 8'hff};
    end
`endif
endmodule

// File: tb/tb_ov5640_init_seq.sv
// tb_ov5640_init_seq: directed bench for ov5640_init_seq with a registered ROM model and a scripted SCCB slave.
module tb_ov5640_init_seq;
  logic clk = 1'b0, reset, re_init, wr_req, wr_done, wr_ack_err, busy, init_done, init_err;
  logic [7:0] rom_addr, err_index, wr_data;
  logic [23:0] rom_q;
  logic [15:0] wr_addr;
  logic [23:0] rom [0:255];
  int cyc = 0, vectors = 0, errs = 0, t_req = 0, t_done = 0, t_rel = 0, prev = 0, reqs = 0;
`ifdef OV5640_INIT_READBACK_EN
  logic rd_req, rd_done, init_mismatch;
  logic [7:0] rd_data, mismatch_cnt;
  logic [15:0] bad_addr;
`endif
  ov5640_init_seq #(.ADDR_WIDTH(8), .REG_NUM(4), .POWERUP_CYCLES(10), .SWRESET_CYCLES(50), .MAX_RETRY(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .re_init    (re_init),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .wr_ack_err (wr_ack_err),
    .busy       (busy),
    .init_done  (init_done),
    .init_err   (init_err),
    .err_index  (err_index)
`ifdef OV5640_INIT_READBACK_EN
    ,
    .rd_req        (rd_req),
    .rd_done       (rd_done),
    .rd_data       (rd_data),
    .init_mismatch (init_mismatch),
    .mismatch_cnt  (mismatch_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= rom[rom_addr];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    while (wr_req !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req seen"}, n < 300, 1);
    t_req = cyc;
  endtask
  task automatic wr(input int i, input logic nack);
    logic [15:0] a;
    logic [7:0] d;
    a = rom[i][23:8];
    d = rom[i][7:0];
    wait_req($sformatf("e%0d", i));
    chk($sformatf("e%0d addr", i), wr_addr, a);
    chk($sformatf("e%0d data", i), wr_data, d);
    chk($sformatf("e%0d rom_addr", i), rom_addr, i);
    @(negedge clk);
    chk($sformatf("e%0d req pulse", i), wr_req, 0);
    @(negedge clk);
    chk($sformatf("e%0d addr hold", i), {wr_addr, wr_data}, {a, d});
    wr_done = 1'b1;
    wr_ack_err = nack;
    t_done = cyc;
    @(negedge clk);
    wr_done = 1'b0;
    wr_ack_err = 1'b0;
`ifdef OV5640_INIT_READBACK_EN
    if (!nack && a != 16'h3008) begin
      int n = 0;
      while (rd_req !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("e%0d rd_req seen", i), n < 50, 1);
      rd_done = 1'b1;
      rd_data = (a == bad_addr) ? 8'h00 : d;
      @(negedge clk);
      rd_done = 1'b0;
    end
`endif
  endtask
  task automatic check_done(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, " init_done"}, init_done, 1);
    chk({tag, " busy"}, busy, 0);
  endtask
  task automatic pulse_reinit();
    re_init = 1'b1;
    @(negedge clk);
    re_init = 1'b0;
    chk("reinit busy", busy, 1);
    chk("reinit init_done", init_done, 0);
  endtask
  initial begin
    reset = 1'b1;
    re_init = 1'b0;
    wr_done = 1'b0;
    wr_ack_err = 1'b0;
`ifdef OV5640_INIT_READBACK_EN
    rd_done = 1'b0;
    rd_data = 8'h00;
    bad_addr = 16'h0000;
`endif
    for (int i = 0; i < 256; i++) rom[i] = 24'h0;
    rom[0] = 24'h3103_11;
    rom[1] = 24'h3017_ff;
    rom[2] = 24'h3034_1a;
    rom[3] = 24'h3037_13;
    repeat (3) @(negedge clk);
    chk("rst rom_addr", rom_addr, 0);
    chk("rst wr_req", wr_req, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst busy", busy, 1);
    chk("rst init_done", init_done, 0);
    chk("rst init_err", init_err, 0);
    chk("rst err_index", err_index, 0);
    reset = 1'b0;
    t_rel = cyc;
    wr(0, 1'b0);
    chk("powerup wait", (t_req - t_rel) >= 10, 1);
    wr(1, 1'b0);
    wr(2, 1'b0);
    wr(3, 1'b0);
    check_done("basic");
    rom[1] = 24'h3008_82;
    pulse_reinit();
    wr(0, 1'b0);
    wr(1, 1'b0);
    prev = t_done;
    wr(2, 1'b0);
    chk("swrst gap", (t_req - prev) >= 50, 1);
    wr(3, 1'b0);
    check_done("swrst");
    rom[1] = 24'h3008_42;
    pulse_reinit();
    wr(0, 1'b0);
    wr(1, 1'b0);
    prev = t_done;
    wr(2, 1'b0);
    chk("no swrst gap", t_req - prev, 4);
    wr(3, 1'b0);
    check_done("noswrst");
    rom[1] = 24'h3017_ff;
    pulse_reinit();
    wr(0, 1'b0);
    wr(1, 1'b0);
    wr(2, 1'b1);
    wr(2, 1'b0);
    wr(3, 1'b0);
    check_done("retry");
    chk("retry init_err", init_err, 0);
    pulse_reinit();
    wr(0, 1'b0);
    wr(1, 1'b0);
    repeat (4) wr(2, 1'b1);
    repeat (3) @(negedge clk);
    chk("exhaust init_err", init_err, 1);
    chk("exhaust err_index", err_index, 2);
    chk("exhaust busy", busy, 0);
    chk("exhaust init_done", init_done, 0);
    reqs = 0;
    repeat (30) begin
      @(negedge clk);
      reqs += int'(wr_req);
    end
    chk("exhaust quiet", reqs, 0);
    pulse_reinit();
    chk("reinit init_err", init_err, 0);
    chk("reinit err_index", err_index, 0);
    wr(0, 1'b0);
    wr(1, 1'b0);
    wr(2, 1'b0);
    wr(3, 1'b0);
    check_done("restart");
    pulse_reinit();
    wr(0, 1'b0);
    wr(1, 1'b0);
    wr(2, 1'b0);
    wait_req("e3 pre-reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst wr_req", wr_req, 0);
    chk("midrst init_done", init_done, 0);
    chk("midrst busy", busy, 1);
    chk("midrst rom_addr", rom_addr, 0);
    reset = 1'b0;
    t_rel = cyc;
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    wr(0, 1'b0);
    chk("midrst powerup wait", (t_req - t_rel) >= 10, 1);
    wr(1, 1'b0);
    wr(2, 1'b0);
    wr(3, 1'b0);
    check_done("midrst");
    chk("midrst init_err", init_err, 0);
`ifdef OV5640_INIT_READBACK_EN
    chk("rb clean cnt", mismatch_cnt, 0);
    bad_addr = 16'h3017;
    pulse_reinit();
    wr(0, 1'b0);
    wr(1, 1'b0);
    wr(2, 1'b0);
    wr(3, 1'b0);
    check_done("readback");
    chk("rb init_mismatch", init_mismatch, 1);
    chk("rb mismatch_cnt", mismatch_cnt, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
